// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Fetch PC register: hold, advance by one word, or load a redirect target.
module fetch_pc_reg
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] fpc_o
);

    logic [31:0] fpc_q;
    logic [31:0] fpc_d;

    // Redirect beats increment; the low two bits of a target are dropped.
    always_comb begin
        fpc_d = fpc_q;
        if (load_i) begin
            fpc_d = load_pc_i & WORD_MASK;
        end else if (inc_i) begin
            fpc_d = fpc_q + PC_INC;
        end
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fpc_q <= RESET_PC & WORD_MASK;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    assign fpc_o = fpc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, instruction register,
// stall and redirect handling (including redirects while a request is open).
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request to fpc open, waiting for ack
// ISSUE | instruction held for decode, no request
// DRAIN | redirected request still open; its data is discarded
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_t state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  fpc;
    logic         fpc_inc;
    logic         fpc_load;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_fetch_pc_reg (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .inc_i    (fpc_inc),
        .load_i   (fpc_load),
        .load_pc_i(redirect_pc),
        .fpc_o    (fpc)
    );

    // Next state, instruction register and fpc control.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        drain_addr_d = drain_addr_q;
        fpc_inc      = 1'b0;
        fpc_load     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack && redirect_valid) begin
                    fpc_load = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = fpc;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else if (redirect_valid) begin
                    // The memory still owns the old address until it acks.
                    drain_addr_d = fpc;
                    fpc_load     = 1'b1;
                    state_d      = DRAIN;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    fpc_load = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = FETCH;
                end else if (!stall) begin
                    fpc_inc = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                fpc_load = redirect_valid;
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            instr_q      <= 32'h0;
            pc_q         <= 32'h0;
            valid_q      <= 1'b0;
            drain_addr_q <= RESET_PC & WORD_MASK;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = ((state_q == DRAIN) ? drain_addr_q : fpc) & WORD_MASK;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic        w_rst_n = 1'b0;
    logic        w_ack = 1'b1;
    logic [31:0] w_rdata = 32'h0000_0020;
    logic        w_stall = 1'b0;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = 32'h0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .funct         (funct),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk           (clk),
        .rst_n         (w_rst_n),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (w_ack),
        .imem_rdata    (w_rdata),
        .stall         (w_stall),
        .redirect_valid(w_redir),
        .redirect_pc   (w_redir_pc),
        .instr_valid   (w_valid),
        .instr         (w_instr),
        .opcode        (w_opcode),
        .funct         (w_funct),
        .pc            (w_pc),
        .pc_plus4      (w_pc_plus4)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stl,
                                input logic redir, input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic vld, input logic [31:0] ins,
                                input logic [31:0] p);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stl; v.redir = redir; v.redir_pc = rpc;
        v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_instr = ins; v.exp_pc = p;
        return v;
    endfunction

    initial begin
        logic [31:0] ei;
        logic [31:0] ep;
        //              ack rdata          stl rdr rpc            req addr           vld instr          pc
        vecs[0]  = mk(0, 32'h0,          1, 1, 32'h0000_0300, 0, 32'h0000_0000, 0, 32'h0,          32'h0);
        vecs[1]  = mk(1, 32'h0000_0020,  0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,          32'h0);
        vecs[2]  = mk(0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'h0000_0020,  32'h0);
        vecs[3]  = mk(0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0000_0020,  32'h0);
        vecs[4]  = mk(0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0000_0020,  32'h0);
        vecs[5]  = mk(0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0000_0020,  32'h0);
        vecs[6]  = mk(1, 32'h8C01_0004,  0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0000_0020,  32'h0);
        vecs[7]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h8C01_0004,  32'h4);
        vecs[8]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h8C01_0004,  32'h4);
        vecs[9]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h8C01_0004,  32'h4);
        vecs[10] = mk(0, 32'h0,          1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h8C01_0004,  32'h4);
        vecs[11] = mk(0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h8C01_0004,  32'h4);
        vecs[12] = mk(1, 32'h0022_182A,  0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h8C01_0004,  32'h4);
        vecs[13] = mk(0, 32'h0,          0, 1, 32'h0000_0103, 0, 32'h0000_0008, 1, 32'h0022_182A,  32'h8);
        vecs[14] = mk(1, 32'h1000_0005,  0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0022_182A,  32'h8);
        vecs[15] = mk(0, 32'h0,          1, 1, 32'h0000_0008, 0, 32'h0000_0100, 1, 32'h1000_0005,  32'h100);
        vecs[16] = mk(0, 32'h0,          0, 1, 32'h0000_0040, 1, 32'h0000_0008, 0, 32'h1000_0005,  32'h100);
        vecs[17] = mk(0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h1000_0005,  32'h100);
        vecs[18] = mk(1, 32'hDEAD_BEEF,  0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h1000_0005,  32'h100);
        vecs[19] = mk(1, 32'h0800_0010,  0, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h1000_0005,  32'h100);
        vecs[20] = mk(0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0040, 1, 32'h0800_0010,  32'h40);
        vecs[21] = mk(1, 32'hBAD0_0000,  0, 1, 32'h0000_0082, 1, 32'h0000_0044, 0, 32'h0800_0010,  32'h40);
        vecs[22] = mk(1, 32'h2000_0001,  0, 0, 32'h0,         1, 32'h0000_0080, 0, 32'h0800_0010,  32'h40);
        vecs[23] = mk(0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0080, 1, 32'h2000_0001,  32'h80);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            imem_ack       = vecs[i].ack;
            imem_rdata     = vecs[i].rdata;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            #1;
            ei = vecs[i].exp_instr;
            ep = vecs[i].exp_pc;
            chk("imem_req",    i, {31'h0, imem_req},    {31'h0, vecs[i].exp_req});
            chk("imem_addr",   i, imem_addr,            vecs[i].exp_addr);
            chk("instr_valid", i, {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
            chk("instr",       i, instr,                ei);
            chk("opcode",      i, {26'h0, opcode},      {26'h0, ei[31:26]});
            chk("funct",       i, {26'h0, funct},       {26'h0, ei[5:0]});
            chk("pc",          i, pc,                   ep);
            chk("pc_plus4",    i, pc_plus4,             ep + 32'd4);
            @(negedge clk);
        end

        // Mid-request reset: step 24 is FETCH to 0x84 with no ack.
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("pre_rst_req",  24, {31'h0, imem_req}, 32'h1);
        chk("pre_rst_addr", 24, imem_addr, 32'h0000_0084);
        rst_n = 1'b0;
        #1;
        chk("rst_req",      24, {31'h0, imem_req},    32'h0);
        chk("rst_addr",     24, imem_addr,            32'h0);
        chk("rst_valid",    24, {31'h0, instr_valid}, 32'h0);
        chk("rst_instr",    24, instr,                32'h0);
        chk("rst_opcode",   24, {26'h0, opcode},      32'h0);
        chk("rst_funct",    24, {26'h0, funct},       32'h0);
        chk("rst_pc",       24, pc,                   32'h0);
        chk("rst_pc_plus4", 24, pc_plus4,             32'h4);

        // Wrap-around fetch from 0xFFFF_FFF8 with immediate acks.
        @(negedge clk);
        w_rst_n = 1'b1;
        #1;
        chk("w_idle_req",  0, {31'h0, w_req}, 32'h0);
        chk("w_idle_addr", 0, w_addr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("w_req0",  1, {31'h0, w_req}, 32'h1);
        chk("w_addr0", 1, w_addr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("w_pc0",   2, w_pc, 32'hFFFF_FFF8);
        chk("w_valid0",2, {31'h0, w_valid}, 32'h1);
        @(negedge clk); #1;
        chk("w_addr1", 3, w_addr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("w_pc1",   4, w_pc, 32'hFFFF_FFFC);
        chk("w_pc_plus4_1", 4, w_pc_plus4, 32'h0000_0000);
        @(negedge clk); #1;
        chk("w_req2",  5, {31'h0, w_req}, 32'h1);
        chk("w_addr2", 5, w_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the MIPS single-cycle datapath, sitting directly upstream of `Control_unit`. It holds the fetch PC and issues one request at a time to instruction memory over a req/ack handshake that tolerates variable latency. It latches the returned word into an instruction register and presents `opcode`/`funct` (plus the full word and its PC) to the control and decode logic. It honours stalls and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ack` in 1: read data valid for the current request.
- `imem_rdata` in 32: instruction word; sampled only when `imem_ack`=1.
- `stall` in 1: downstream cannot consume the held instruction.
- `redirect_valid` in 1: branch or jump taken.
- `redirect_pc` in 32: new fetch target; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: `instr`/`opcode`/`funct`/`pc` are valid.
- `instr` out 32: latched instruction word.
- `opcode` out 6: `instr[31:26]`, wired to `Control_unit.opcode`.
- `funct` out 6: `instr[5:0]`, wired to `Control_unit.funct`.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc + 4`, mod 2^32.

## Operation
- State machine states: IDLE, FETCH, ISSUE, DRAIN. The fetch PC (`fpc`) is a register separate from the output `pc`.
- IDLE:
  - Entered on reset.
  - Moves to FETCH on the next clock, unconditionally.
- FETCH:
  - Drive `imem_req`=1 with `imem_addr`=`fpc`; both stay stable until `imem_ack`.
  - On `imem_ack` with no redirect: `instr`<=`imem_rdata`, `pc`<=`fpc`, `instr_valid`<=1, go to ISSUE.
  - On `imem_ack` together with `redirect_valid`: discard the data, `fpc`<=`redirect_pc`, stay in FETCH (a new request starts the next cycle).
  - On `redirect_valid` without `imem_ack`: `fpc`<=`redirect_pc`, go to DRAIN.
- ISSUE:
  - `imem_req`=0.
  - `redirect_valid` takes priority over `stall`: `fpc`<=`redirect_pc`, `instr_valid`<=0, go to FETCH.
  - Else if `stall`: hold every output.
  - Else: `fpc`<=`fpc`+4, `instr_valid`<=0, go to FETCH.
- DRAIN:
  - Keep `imem_req`=1 and `imem_addr` at the old request address until `imem_ack`.
  - On `imem_ack`: discard the data and go to FETCH.
  - A further `redirect_valid` in DRAIN overwrites `fpc`; the last one wins.
- PC arithmetic:
  - All PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - `imem_addr[1:0]` is always 0.

## Timing
- Reset values: state=IDLE, `fpc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `opcode`=0, `funct`=0, `pc`=0, `pc_plus4`=4.
- First `imem_req` is asserted in the second cycle after `rst_n` deasserts.
- `imem_req` and `imem_addr` are decoded from state and `fpc`. `instr`, `pc` and `instr_valid` are registered. `opcode`, `funct` and `pc_plus4` are combinational from the registers.
- Latency: `imem_ack` in cycle N gives `instr_valid`=1 in cycle N+1.
- Best-case throughput, with `imem_ack` in the same cycle as the request: one instruction every 2 cycles.
- Redirect latency: a redirect seen in ISSUE at cycle N gives `imem_addr`=`redirect_pc` with `imem_req`=1 in cycle N+1.
- A redirect during an outstanding request costs exactly one extra handshake; stale data never reaches `instr`.
- Reset asserted mid-request: every output returns to its reset value immediately. The memory side must drop any in-flight ack on reset.
- `redirect_valid` and `stall` are ignored in IDLE.

## Structure
- Shared package `mips_fetch_pkg`:
  - state enum `fetch_state_t` (IDLE, FETCH, ISSUE, DRAIN);
  - field-slice constants `OPCODE_MSB`=31, `OPCODE_LSB`=26, `FUNCT_MSB`=5, `FUNCT_LSB`=0;
  - `PC_INC`=32'd4.
- One natural sub-module: `fetch_pc_reg`, which holds `fpc` and selects among hold, +4 and redirect (with masking of bits [1:0]). Everything else lives in the top-level FSM.

## Test plan
- Reset, then instruction memory holds 32'h0000_0020 at address 0 with 1-cycle ack: `imem_req` rises in cycle 2 with `imem_addr`=0; after the ack, `instr_valid`=1, `opcode`=0x00, `funct`=0x20, `pc`=0, `pc_plus4`=4.
- Ack delayed 3 cycles, then `stall`=1 for 4 cycles: `imem_req`/`imem_addr` stay stable while waiting; `instr` is held for all 4 stall cycles; the next request goes to address 4.
- Redirect to 32'h0000_0103 during ISSUE: the next request has `imem_addr`=32'h0000_0100 and `instr_valid` drops for that cycle.
- Redirect to 0x40 while a request to 0x8 is pending: DRAIN keeps address 0x8 until ack; that data (32'hDEAD_BEEF) never appears on `instr`; the next request is 0x40.
- `redirect_valid` and `stall` asserted in the same ISSUE cycle: the redirect wins.
- Sequential fetch from `RESET_PC`=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_n`=0 in the middle of a FETCH: all outputs take their reset values immediately.
